// File: rtl/iz_param_loader.sv
// -----------------------------------------------------------------------------
// iz_param_loader
//
// Byte-serial configuration loader for the Izhikevich neuron core. Framed
// parameter packets arrive over an 8-bit valid/ready stream:
//
//   SYNC_BYTE, a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi [, checksum]
//
// The payload is collected in shadow registers. All four 16-bit parameters
// are committed to the neuron on a single edge, so a partial set is never
// visible. An aborted frame leaves the committed parameters untouched.
//
// Build option:
//   IZ_LOADER_CHECKSUM_EN  When defined, a trailing checksum byte (XOR of
//                          the 8 payload bytes) is expected and checked. A
//                          mismatch aborts the frame. When undefined, the
//                          frame is 9 bytes, COMMIT follows d_hi directly and
//                          load_error only reports timeouts.
//
// Ports:
//   clk           sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   load_data     stream byte
//   load_valid    load_data is valid
//   load_ready    loader can accept a byte (low only during COMMIT)
//   param_a..d    committed model parameters
//   params_ready  committed set is valid; the neuron integrates while high
//   load_busy     frame in progress (state other than IDLE)
//   load_error    one-cycle pulse when a frame is aborted
// -----------------------------------------------------------------------------
module iz_param_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] DEF_A          = 16'h0002,
  parameter logic [15:0] DEF_B          = 16'h000D,
  parameter logic [15:0] DEF_C          = 16'hEFC0,
  parameter logic [15:0] DEF_D          = 16'h0200,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [15:0] param_a,
  output logic [15:0] param_b,
  output logic [15:0] param_c,
  output logic [15:0] param_d,
  output logic        params_ready,
  output logic        load_busy,
  output logic        load_error
);

  // Gap counter only has to reach TIMEOUT_CYCLES; keep at least one bit so
  // the disabled-timeout build still elaborates cleanly.
  localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
`ifdef IZ_LOADER_CHECKSUM_EN
    ST_CHECK  = 2'd2,
`endif
    ST_COMMIT = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,        state_d;
  logic [2:0]         byte_idx_q,     byte_idx_d;
  logic [GAP_W-1:0]   gap_q,          gap_d;
  logic [7:0]         shadow_q [8];
  logic [7:0]         shadow_d [8];
  logic               ready_save_q,   ready_save_d;
  logic [15:0]        param_a_q,      param_a_d;
  logic [15:0]        param_b_q,      param_b_d;
  logic [15:0]        param_c_q,      param_c_d;
  logic [15:0]        param_d_q,      param_d_d;
  logic               params_ready_q, params_ready_d;
  logic               load_ready_q,   load_ready_d;
  logic               load_busy_q,    load_busy_d;
  logic               load_error_q,   load_error_d;
`ifdef IZ_LOADER_CHECKSUM_EN
  logic [7:0]         xor_q,          xor_d;
`endif

  logic accept;
  logic timeout_hit;
  logic abort;

  // load_ready is a registered output, so acceptance never depends
  // combinationally on the upstream valid.
  assign accept = load_valid && load_ready_q;

  // Abort happens on the edge where the idle count would reach
  // TIMEOUT_CYCLES. It is only evaluated when no byte is accepted, so a byte
  // landing on that exact edge wins and restarts the count.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(gap_q) + 32'd1) == TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every _d signal takes its _q value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    gap_d          = gap_q;
    shadow_d       = shadow_q;
    ready_save_d   = ready_save_q;
    param_a_d      = param_a_q;
    param_b_d      = param_b_q;
    param_c_d      = param_c_q;
    param_d_d      = param_d_q;
    params_ready_d = params_ready_q;
    load_error_d   = 1'b0;
    abort          = 1'b0;
`ifdef IZ_LOADER_CHECKSUM_EN
    xor_d          = xor_q;
`endif

    case (state_q)
      ST_IDLE: begin
        gap_d = '0;
        // Non-sync bytes are swallowed silently: line noise between frames.
        if (accept && (load_data == SYNC_BYTE)) begin
          state_d        = ST_RECV;
          byte_idx_d     = 3'd0;
          // Hold the neuron during the reload, but remember the previous
          // readiness so an aborted frame can restore it.
          ready_save_d   = params_ready_q;
          params_ready_d = 1'b0;
`ifdef IZ_LOADER_CHECKSUM_EN
          xor_d          = 8'h00;
`endif
        end
      end

      ST_RECV: begin
        // A sync value in here is plain payload; there is no resync.
        if (accept) begin
          shadow_d[byte_idx_q] = load_data;
          byte_idx_d           = byte_idx_q + 3'd1;
          gap_d                = '0;
`ifdef IZ_LOADER_CHECKSUM_EN
          xor_d                = xor_q ^ load_data;
`endif
          if (byte_idx_q == 3'd7) begin
`ifdef IZ_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_COMMIT;
`endif
          end
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else if (gap_q != {GAP_W{1'b1}}) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

`ifdef IZ_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          gap_d = '0;
          if (load_data == xor_q) begin
            state_d = ST_COMMIT;
          end else begin
            abort = 1'b1;
          end
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else if (gap_q != {GAP_W{1'b1}}) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
`endif

      ST_COMMIT: begin
        // Single edge: all four words and the ready flag move together.
        param_a_d      = {shadow_q[1], shadow_q[0]};
        param_b_d      = {shadow_q[3], shadow_q[2]};
        param_c_d      = {shadow_q[5], shadow_q[4]};
        param_d_d      = {shadow_q[7], shadow_q[6]};
        params_ready_d = 1'b1;
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Common abort path for checksum mismatch and timeout. Committed
    // parameters are left alone; only the staging data is thrown away.
    if (abort) begin
      state_d        = ST_IDLE;
      load_error_d   = 1'b1;
      params_ready_d = ready_save_q;
      gap_d          = '0;
      shadow_d       = '{default: 8'h00};
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    load_ready_d = (state_d != ST_COMMIT);
    load_busy_d  = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every flop samples the values from
  // before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      byte_idx_q     <= 3'd0;
      gap_q          <= '0;
      // NOTE: the shadow array is only 8 bytes of flops, so it is reset along
      // with everything else; a stale payload can never leak into a commit.
      shadow_q       <= '{default: 8'h00};
      ready_save_q   <= 1'b0;
      param_a_q      <= DEF_A;
      param_b_q      <= DEF_B;
      param_c_q      <= DEF_C;
      param_d_q      <= DEF_D;
      params_ready_q <= 1'b0;
      load_ready_q   <= 1'b1;
      load_busy_q    <= 1'b0;
      load_error_q   <= 1'b0;
`ifdef IZ_LOADER_CHECKSUM_EN
      xor_q          <= 8'h00;
`endif
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      gap_q          <= gap_d;
      shadow_q       <= shadow_d;
      ready_save_q   <= ready_save_d;
      param_a_q      <= param_a_d;
      param_b_q      <= param_b_d;
      param_c_q      <= param_c_d;
      param_d_q      <= param_d_d;
      params_ready_q <= params_ready_d;
      load_ready_q   <= load_ready_d;
      load_busy_q    <= load_busy_d;
      load_error_q   <= load_error_d;
`ifdef IZ_LOADER_CHECKSUM_EN
      xor_q          <= xor_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign load_ready   = load_ready_q;
  assign param_a      = param_a_q;
  assign param_b      = param_b_q;
  assign param_c      = param_c_q;
  assign param_d      = param_d_q;
  assign params_ready = params_ready_q;
  assign load_busy    = load_busy_q;
  assign load_error   = load_error_q;

endmodule

// File: tb/tb_iz_param_loader.sv
// -----------------------------------------------------------------------------
// tb_iz_param_loader
//
// Self-checking bench for iz_param_loader. A table of frames is driven
// through the byte stream; frames expected to commit push their parameter
// set into a scoreboard queue, and a monitor pops and compares it on the
// cycle after COMMIT. Hand-written sequences cover reset, IDLE noise,
// timeout, a byte on the exact timeout edge and reset in mid-frame.
// Works with and without IZ_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_iz_param_loader;

  localparam int unsigned TMO  = 8;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [63:0] DEFAULTS = {16'h0002, 16'h000D, 16'hEFC0, 16'h0200};
`ifdef IZ_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] param_a, param_b, param_c, param_d;
  logic        params_ready;
  logic        load_busy;
  logic        load_error;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q [$];
  logic [63:0] model_params;
  logic        model_ready;

  typedef struct {
    logic [63:0] pay;   // payload byte i at pay[8*i +: 8]
    logic [7:0]  flip;  // XOR mask applied to the sent checksum
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  iz_param_loader #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .param_a      (param_a),
    .param_b      (param_b),
    .param_c      (param_c),
    .param_d      (param_d),
    .params_ready (params_ready),
    .load_busy    (load_busy),
    .load_error   (load_error)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] to_params(input logic [63:0] p);
    return {p[15:0], p[31:16], p[47:32], p[63:48]};
  endfunction

  function automatic logic [7:0] xor8(input logic [63:0] p);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 8; i++) x ^= p[8*i +: 8];
    return x;
  endfunction

  function automatic logic [63:0] dut_params();
    return {param_a, param_b, param_c, param_d};
  endfunction

  // Drive one byte and return 1 ns after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    logic rdy = 1'b0;
    int   waited = 0;
    load_data  = b;
    load_valid = 1'b1;
    while (!rdy && waited < 20) begin
      rdy = load_ready;
      @(posedge clk);
      waited++;
    end
    check("byte_accept", 64'(rdy), 64'd1);
    #1 load_valid = 1'b0;
  endtask

  // Send a whole frame; optionally idle gap_len cycles after payload byte
  // gap_after. Checks the commit/abort outcome.
  task automatic send_frame(input logic [63:0] p, input logic [7:0] flip,
                            input int gap_after, input int gap_len);
    bit expect_commit;
    expect_commit = !CK_EN || (flip == 8'h00);
    send_byte(SYNC);
    @(negedge clk);
    check("ready_drop_on_sync", 64'(params_ready), 64'd0);
    check("busy_in_frame", 64'(load_busy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      send_byte(p[8*i +: 8]);
      if (i == gap_after) begin
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    if (CK_EN) send_byte(xor8(p) ^ flip);
    if (expect_commit) begin
      exp_q.push_back(to_params(p));
      model_params = to_params(p);
      model_ready  = 1'b1;
    end
    @(negedge clk);
    if (expect_commit) begin
      check("commit_load_ready_low", 64'(load_ready), 64'd0);
      check("commit_no_error", 64'(load_error), 64'd0);
      check("commit_not_yet_ready", 64'(params_ready), 64'd0);
    end else begin
      check("abort_error_pulse", 64'(load_error), 64'd1);
      check("abort_ready_restored", 64'(params_ready), 64'(model_ready));
      check("abort_idle", 64'(load_busy), 64'd0);
      @(negedge clk);
      check("abort_error_one_cycle", 64'(load_error), 64'd0);
    end
    @(negedge clk);
    check("frame_params", dut_params(), model_params);
    check("frame_params_ready", 64'(params_ready), 64'(model_ready));
  endtask

  // Scoreboard monitor: the cycle after load_ready was low (COMMIT) the
  // committed set must match the oldest expected set.
  logic prev_commit = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset_n) begin
      prev_commit = 1'b0;
    end else begin
      if (prev_commit) begin
        check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_params", dut_params(), e);
          check("sb_params_ready", 64'(params_ready), 64'd1);
          check("sb_commit_one_cycle", 64'(load_ready), 64'd1);
        end
      end
      prev_commit = !load_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{pay: 64'h0200_EFC0_000D_0002, flip: 8'h00};
    vecs[1] = '{pay: 64'h0000_0000_0000_1234, flip: 8'h26};
    vecs[2] = '{pay: 64'h7766_5544_3322_11A5, flip: 8'h00};
    vecs[3] = '{pay: 64'h0000_0001_8000_FFFF, flip: 8'h00};
    vecs[4] = '{pay: 64'hA5A5_A5A5_A5A5_A5A5, flip: 8'h01};

    model_params = DEFAULTS;
    model_ready  = 1'b0;

    // ---- Reset ----
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_params", dut_params(), DEFAULTS);
    check("reset_params_ready", 64'(params_ready), 64'd0);
    check("reset_load_ready", 64'(load_ready), 64'd1);
    check("reset_busy", 64'(load_busy), 64'd0);
    check("reset_error", 64'(load_error), 64'd0);
    @(posedge clk);
    #1;

    // ---- Table-driven frames ----
    for (int v = 0; v < 5; v++) begin
      if (v == 2) begin
        // Noise in IDLE is swallowed with no state change.
        send_byte(8'hFF);
        send_byte(8'h3C);
        @(negedge clk);
        check("noise_busy", 64'(load_busy), 64'd0);
        check("noise_error", 64'(load_error), 64'd0);
        check("noise_ready", 64'(params_ready), 64'(model_ready));
        check("noise_params", dut_params(), model_params);
        @(posedge clk);
        #1;
      end
      send_frame(vecs[v].pay, vecs[v].flip, -1, 0);
      if (v == 2) check("in_frame_sync_a_lo", 64'(param_a[7:0]), 64'hA5);
      @(posedge clk);
      #1;
    end

    // ---- Timeout: 8 idle cycles inside a frame abort it ----
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("tmo_still_busy", 64'(load_busy), 64'd1);
      check("tmo_no_early_error", 64'(load_error), 64'd0);
    end
    @(negedge clk);
    check("tmo_error_pulse", 64'(load_error), 64'd1);
    check("tmo_idle", 64'(load_busy), 64'd0);
    check("tmo_ready_restored", 64'(params_ready), 64'(model_ready));
    check("tmo_params_kept", dut_params(), model_params);
    @(negedge clk);
    check("tmo_error_one_cycle", 64'(load_error), 64'd0);
    @(posedge clk);
    #1;

    // ---- Byte on the exact timeout edge wins ----
    send_frame(64'h5678_1234_000D_0001, 8'h00, 1, TMO - 1);
    @(posedge clk);
    #1;

    // ---- Reset mid-frame with load_valid held high ----
    send_byte(SYNC);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    load_data  = 8'h55;
    load_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset_params", dut_params(), DEFAULTS);
    check("mid_reset_params_ready", 64'(params_ready), 64'd0);
    check("mid_reset_busy", 64'(load_busy), 64'd0);
    check("mid_reset_load_ready", 64'(load_ready), 64'd1);
    check("mid_reset_error", 64'(load_error), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    load_valid = 1'b0;
    reset_n    = 1'b1;
    model_params = DEFAULTS;
    model_ready  = 1'b0;
    @(posedge clk);
    #1;
    send_frame(64'hCAFE_BEEF_0123_4567, 8'h00, -1, 0);

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
